// File: rtl/flash_ahb_arbiter.sv
// Round-robin arbiter that puts a fetch port and a data port onto one AHB-Lite read path to an XIP flash.
// Latency: a read is granted in cycle N and answers in N+3, plus one cycle per HREADY-low cycle. A rejected write answers in N+1.
// Backpressure: only one transaction is in flight, so no grant is issued until the response cycle is over. Waiting requesters hold req_i.
// Ports: clk_i/rst_i; per-port req_i/gnt_o/addr_i/we_i/aid_i; shared rvalid_o/rdata_o/err_o/rid_o;
//        AHB-Lite master side HSEL/HADDR/HTRANS/HWRITE/HREADY/HRDATA/HRESP.
module flash_ahb_arbiter #(
    parameter int unsigned AidWidth = 1,
    parameter logic [31:0] ErrData  = 32'hBADCAB1E
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               req_i,
    output logic [1:0]               gnt_o,
    input  logic [1:0][31:0]         addr_i,
    input  logic [1:0]               we_i,
    input  logic [1:0][AidWidth-1:0] aid_i,
    output logic [1:0]               rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic [AidWidth-1:0]      rid_o,
    output logic                     HSEL,
    output logic [31:0]              HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    input  logic                     HREADY,
    input  logic [31:0]              HRDATA,
    input  logic                     HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    state_e                state_q;
    logic                  last_q;      // index of the port granted most recently
    logic                  win_q;       // index of the port that owns the transaction in flight
    logic [AidWidth-1:0]   aid_q;
    logic [1:0]            rvalid_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [AidWidth-1:0]   rid_q;
    logic                  hsel_q;
    logic [1:0]            htrans_q;
    logic [31:0]           haddr_q;
    logic                  win_idx;

    // The bus is word-addressed, so the byte-offset bits of the request address are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{addr_i[0][1:0], addr_i[1][1:0]};

    // Grant is combinational, so a requester learns it won in the same cycle it asks.
    // It is gated by reset so that no grant can show while the state is being cleared.
    always_comb begin
        gnt_o = 2'b00;
        if (state_q == S_IDLE && !rst_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    assign win_idx = gnt_o[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            aid_q    <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rid_q    <= '0;
            hsel_q   <= 1'b0;
            htrans_q <= HtransIdle;
            haddr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_o != 2'b00) begin
                        win_q  <= win_idx;
                        last_q <= win_idx;
                        aid_q  <= aid_i[win_idx];
                        if (we_i[win_idx]) begin
                            // The flash is read-only: answer the write locally and never touch the bus.
                            rvalid_q <= gnt_o;
                            rdata_q  <= ErrData;
                            err_q    <= 1'b1;
                            rid_q    <= aid_i[win_idx];
                            state_q  <= S_RESP;
                        end else begin
                            hsel_q   <= 1'b1;
                            htrans_q <= HtransNonseq;
                            haddr_q  <= {addr_i[win_idx][31:2], 2'b00};
                            state_q  <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // Address-phase outputs stay frozen until the slave accepts them.
                    if (HREADY) begin
                        hsel_q   <= 1'b0;
                        htrans_q <= HtransIdle;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        rdata_q  <= HRDATA;
                        err_q    <= HRESP;
                        rid_q    <= aid_q;
                        rvalid_q <= win_q ? 2'b10 : 2'b01;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    rvalid_q <= 2'b00;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign rid_o    = rid_q;
    assign HSEL     = hsel_q;
    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HWRITE   = 1'b0;

endmodule

// File: tb/tb_flash_ahb_arbiter.sv
// Self-checking bench for flash_ahb_arbiter: expected responses are queued at grant time and checked by a response monitor.
// Latency: each scenario checks grant-to-rvalid distance against the cycle counter.
// Backpressure: HREADY wait states are driven directly by the scenario tasks.
module tb_flash_ahb_arbiter;

    localparam int AW = 1;

    typedef struct {
        logic [1:0]    port;
        logic [31:0]   data;
        logic          err;
        logic [AW-1:0] rid;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [1:0]          req_i;
    logic [1:0]          gnt_o;
    logic [1:0][31:0]    addr_i;
    logic [1:0]          we_i;
    logic [1:0][AW-1:0]  aid_i;
    logic [1:0]          rvalid_o;
    logic [31:0]         rdata_o;
    logic                err_o;
    logic [AW-1:0]       rid_o;
    logic                HSEL;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic                HREADY;
    logic [31:0]         HRDATA;
    logic                HRESP;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    flash_ahb_arbiter #(.AidWidth(AW), .ErrData(32'hBADCAB1E)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .aid_i(aid_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .rid_o(rid_o),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        #1;
        if (rvalid_o !== 2'b00) begin
            checks++;
            if (gnt_o !== 2'b00) begin
                errors++;
                $display("FAIL rvalid_gnt_excl: gnt_o=%b while rvalid_o=%b, required gnt_o=00", gnt_o, rvalid_o);
            end
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: rvalid_o=%b rdata=%h at cycle %0d, none expected", rvalid_o, rdata_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if ({rvalid_o, rdata_o, err_o, rid_o} !== {mon_e.port, mon_e.data, mon_e.err, mon_e.rid}) begin
                    errors++;
                    $display("FAIL response: got rvalid=%b rdata=%h err=%b rid=%h, required rvalid=%b rdata=%h err=%b rid=%h",
                             rvalid_o, rdata_o, err_o, rid_o, mon_e.port, mon_e.data, mon_e.err, mon_e.rid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Caller is positioned just after a negedge; looks at the current cycle first, then later ones.
    task automatic wait_rvalid(output int c, output bit ok);
        ok = 1'b0;
        c  = -1;
        for (int i = 0; i < 40; i++) begin
            if (rvalid_o !== 2'b00) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rvalid_timeout: no rvalid_o within 40 cycles, required one");
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; req_i = 2'b11; we_i = 2'b00; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        addr_i = '0; aid_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (gnt_o !== 2'b00)    begin errors++; $display("FAIL reset_gnt: got %b required 00", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b required 00", rvalid_o); end
        checks++; if (HSEL !== 1'b0)      begin errors++; $display("FAIL reset_hsel: got %b required 0", HSEL); end
        checks++; if (HTRANS !== 2'b00)   begin errors++; $display("FAIL reset_htrans: got %b required 00", HTRANS); end
        checks++; if (HADDR !== 32'h0)    begin errors++; $display("FAIL reset_haddr: got %h required 0", HADDR); end
        checks++; if ({rdata_o, err_o, rid_o} !== {32'h0, 1'b0, {AW{1'b0}}})
            begin errors++; $display("FAIL reset_resp: got rdata=%h err=%b rid=%h required zeros", rdata_o, err_o, rid_o); end
        checks++; if (HWRITE !== 1'b0)    begin errors++; $display("FAIL hwrite: got %b required 0", HWRITE); end
        rst_i = 1'b0; req_i = 2'b00;
    endtask

    task automatic test_read_basic;
        int n, c; bit ok;
        @(negedge clk);
        addr_i[0] = 32'h1000_0006; aid_i[0] = 1'b1; we_i = 2'b00; req_i = 2'b01;
        HRDATA = 32'hCAFE_F00D; HREADY = 1'b1; HRESP = 1'b0;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b required 01", gnt_o); end
        sb.push_back('{port: 2'b01, data: 32'hCAFE_F00D, err: 1'b0, rid: 1'b1});
        @(negedge clk); req_i = 2'b00; #1;
        checks++; if ({HSEL, HTRANS, HADDR} !== {1'b1, 2'b10, 32'h1000_0004})
            begin errors++; $display("FAIL read_addr_phase: got hsel=%b htrans=%b haddr=%h required 1 10 10000004", HSEL, HTRANS, HADDR); end
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 3) begin errors++; $display("FAIL read_latency: got %0d required %0d", c - n, 3); end end
    endtask

    task automatic test_round_robin;
        int ng, last_g, c; bit ok;
        logic [1:0] exp_g;
        rst_i = 1'b1; req_i = 2'b11; we_i = 2'b00;
        addr_i[0] = 32'h1000_0100; addr_i[1] = 32'h1000_0200; aid_i[0] = 1'b0; aid_i[1] = 1'b1;
        HRDATA = 32'h1234_5678; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        ng = 0; last_g = -100; exp_g = 2'b01;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            if (gnt_o !== 2'b00) begin
                checks++;
                if (gnt_o !== exp_g) begin errors++; $display("FAIL rr_order: grant %0d got %b required %b", ng, gnt_o, exp_g); end
                if (ng > 0) begin
                    checks++;
                    if (cyc - last_g < 4) begin errors++; $display("FAIL rr_spacing: gap %0d required >= 4", cyc - last_g); end
                end
                sb.push_back('{port: exp_g, data: 32'h1234_5678, err: 1'b0, rid: exp_g[1]});
                last_g = cyc; ng++; exp_g = ~exp_g;
            end
            @(negedge clk);
        end
        req_i = 2'b00;
        checks++; if (ng != 4) begin errors++; $display("FAIL rr_count: got %0d grants required 4", ng); end
        #1;
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != last_g + 3) begin errors++; $display("FAIL rr_latency: got %0d required 3", c - last_g); end end
    endtask

    task automatic test_write_reject;
        int n, c; bit ok;
        @(negedge clk);
        addr_i[1] = 32'h1000_0000; we_i = 2'b10; aid_i[1] = 1'b0; req_i = 2'b10;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b required 10", gnt_o); end
        sb.push_back('{port: 2'b10, data: 32'hBADCAB1E, err: 1'b1, rid: 1'b0});
        @(negedge clk); req_i = 2'b00; we_i = 2'b00; #1;
        checks++; if ({HSEL, HTRANS} !== {1'b0, 2'b00})
            begin errors++; $display("FAIL wr_no_bus: got hsel=%b htrans=%b required 0 00", HSEL, HTRANS); end
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 1) begin errors++; $display("FAIL wr_latency: got %0d required 1", c - n); end end
    endtask

    task automatic test_wait_states;
        int n, c; bit ok;
        @(negedge clk);
        addr_i[0] = 32'h1000_0013; aid_i[0] = 1'b0; we_i = 2'b00; req_i = 2'b01;
        HRDATA = 32'h5555_AAAA; HREADY = 1'b0;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL ws_gnt: got %b required 01", gnt_o); end
        sb.push_back('{port: 2'b01, data: 32'h5555_AAAA, err: 1'b0, rid: 1'b0});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); req_i = 2'b00; #1;
            checks++;
            if (k <= 6) begin
                if ({HSEL, HTRANS, HADDR} !== {1'b1, 2'b10, 32'h1000_0010}) begin
                    errors++;
                    $display("FAIL ws_addr_hold: cycle +%0d got hsel=%b htrans=%b haddr=%h required 1 10 10000010", k, HSEL, HTRANS, HADDR);
                end
            end else begin
                if ({HSEL, HTRANS} !== {1'b0, 2'b00}) begin
                    errors++;
                    $display("FAIL ws_data_idle: cycle +%0d got hsel=%b htrans=%b required 0 00", k, HSEL, HTRANS);
                end
            end
            HREADY = (k == 6 || k == 10);
        end
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 11) begin errors++; $display("FAIL ws_latency: got %0d required 11", c - n); end end
    endtask

    task automatic test_hresp_error;
        int n, c; bit ok;
        @(negedge clk);
        addr_i[1] = 32'h2000_0008; aid_i[1] = 1'b1; we_i = 2'b00; req_i = 2'b10;
        HRDATA = 32'hDEAD_BEEF; HRESP = 1'b1; HREADY = 1'b1;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL err_gnt: got %b required 10", gnt_o); end
        sb.push_back('{port: 2'b10, data: 32'hDEAD_BEEF, err: 1'b1, rid: 1'b1});
        @(negedge clk); req_i = 2'b00; #1;
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 3) begin errors++; $display("FAIL err_latency: got %0d required 3", c - n); end end
        HRESP = 1'b0;
        @(negedge clk);
        addr_i[0] = 32'h1000_0020; aid_i[0] = 1'b0; req_i = 2'b01; HRDATA = 32'h0F0F_0F0F;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL err_next_gnt: got %b required 01", gnt_o); end
        sb.push_back('{port: 2'b01, data: 32'h0F0F_0F0F, err: 1'b0, rid: 1'b0});
        @(negedge clk); req_i = 2'b00; #1;
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 3) begin errors++; $display("FAIL err_next_latency: got %0d required 3", c - n); end end
    endtask

    task automatic test_reset_mid;
        int n, c; bit ok;
        @(negedge clk);
        addr_i[0] = 32'h1000_0030; aid_i[0] = 1'b1; we_i = 2'b00; req_i = 2'b01;
        HRDATA = 32'h7777_7777; HREADY = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rm_gnt: got %b required 01", gnt_o); end
        @(negedge clk); req_i = 2'b00;
        @(negedge clk); HREADY = 1'b0; rst_i = 1'b1; req_i = 2'b11;
        @(negedge clk); #1;
        checks++; if ({gnt_o, rvalid_o} !== 4'b0000)
            begin errors++; $display("FAIL rm_gnt_rvalid: got gnt=%b rvalid=%b required 00 00", gnt_o, rvalid_o); end
        checks++; if ({HSEL, HTRANS, HADDR} !== {1'b0, 2'b00, 32'h0})
            begin errors++; $display("FAIL rm_bus: got hsel=%b htrans=%b haddr=%h required 0 00 0", HSEL, HTRANS, HADDR); end
        checks++; if ({rdata_o, err_o, rid_o} !== {32'h0, 1'b0, {AW{1'b0}}})
            begin errors++; $display("FAIL rm_resp: got rdata=%h err=%b rid=%h required zeros", rdata_o, err_o, rid_o); end
        rst_i = 1'b0; HREADY = 1'b1;
        #1; n = cyc;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rm_tie: got %b required 01", gnt_o); end
        sb.push_back('{port: 2'b01, data: 32'h7777_7777, err: 1'b0, rid: 1'b1});
        @(negedge clk); req_i = 2'b00; #1;
        wait_rvalid(c, ok);
        if (ok) begin checks++; if (c != n + 3) begin errors++; $display("FAIL rm_latency: got %0d required 3", c - n); end end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_round_robin();
        test_write_reject();
        test_wait_states();
        test_hresp_error();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
